// File: rtl/counter_pkg.sv
// counter_pkg: shared overflow-mode constants and load clamp helper for updown_counter_mod
package counter_pkg;
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT = 1;
  function automatic logic [31:0] clamp_to_max(input logic [31:0] val, input logic [31:0] max);
    return val > max ? max : val;
  endfunction
endpackage

// File: rtl/updown_counter_mod_next.sv
// updown_counter_mod_next: comb next count and wrap/err flags from count, step, up_down
module updown_counter_mod_next
  import counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MAX_VAL = 2 ** WIDTH - 1,
  parameter int SAT_MODE = MODE_WRAP
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] step,
  input  logic             up_down,
  output logic [WIDTH-1:0] next_count,
  output logic             wrap_n,
  output logic             err_n
);
  localparam logic [WIDTH:0] MAX = (WIDTH + 1)'(MAX_VAL);
  localparam logic [WIDTH:0] MOD = MAX + 1'b1;
  localparam bit SAT = SAT_MODE == MODE_SAT;
  logic [WIDTH:0] c, s, sum;
  logic bad, idle, over, under;
  assign c = {1'b0, count};
  assign s = {1'b0, step};
  assign sum = c + s;
  always_comb begin
    bad = s > MAX;
    idle = bad || step == '0;
    over = sum > MAX;
    under = c < s;
    next_count = idle ? count : WIDTH'(up_down ? (over ? (SAT ? MAX : sum - MOD) : sum)
                                               : (under ? (SAT ? '0 : c + MOD - s) : c - s));
    wrap_n = !idle && (up_down ? over : under);
    err_n = bad;
  end
endmodule

// File: rtl/updown_counter_mod.sv
// updown_counter_mod: modulo 0..MAX_VAL up/down counter with load, step, wrap/saturate and pulse flags
module updown_counter_mod
  import counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MAX_VAL = 2 ** WIDTH - 1,
  parameter int SAT_MODE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_down,
  input  logic [WIDTH-1:0] step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap,
  output logic             err
);
  if (WIDTH < 2 || MAX_VAL < 1 || MAX_VAL > (2 ** WIDTH) - 1) begin : g_param_err
    $error("updown_counter_mod: illegal WIDTH/MAX_VAL");
  end
  logic [WIDTH-1:0] next_count;
  logic wrap_n, err_n;
  updown_counter_mod_next #(.WIDTH(WIDTH), .MAX_VAL(MAX_VAL), .SAT_MODE(SAT_MODE)) u_next (
    .count(count),
    .step(step),
    .up_down(up_down),
    .next_count(next_count),
    .wrap_n(wrap_n),
    .err_n(err_n)
  );
  assign at_max = count == WIDTH'(MAX_VAL);
  assign at_min = count == '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      wrap <= 1'b0;
      err <= 1'b0;
    end else if (load) begin
      count <= WIDTH'(clamp_to_max(32'(load_val), MAX_VAL));
      wrap <= 1'b0;
      err <= 32'(load_val) > MAX_VAL;
    end else if (en) begin
      count <= next_count;
      wrap <= wrap_n;
      err <= err_n;
    end else begin
      wrap <= 1'b0;
      err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_updown_counter_mod.sv
// tb_updown_counter_mod: scoreboard bench for wrap, saturate and 8-bit binary counter configurations
module tb_updown_counter_mod;
  logic clk = 1'b0;
  logic rst, en, up_down, load;
  logic [3:0] step, load_val;
  logic b_en, b_up;
  logic [3:0] w_count, s_count;
  logic [7:0] b_count;
  logic w_max, w_min, w_wrap, w_err;
  logic s_max, s_min, s_wrap, s_err;
  logic b_max, b_min, b_wrap, b_err;
  typedef struct {
    int id;
    int cnt;
    bit wr;
    bit er;
    string tag;
  } exp_t;
  exp_t q[$];
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  updown_counter_mod #(.WIDTH(4), .MAX_VAL(9), .SAT_MODE(0)) u_w (
    .clk(clk), .rst(rst), .en(en), .up_down(up_down), .step(step), .load(load),
    .load_val(load_val), .count(w_count), .at_max(w_max), .at_min(w_min), .wrap(w_wrap), .err(w_err)
  );
  updown_counter_mod #(.WIDTH(4), .MAX_VAL(9), .SAT_MODE(1)) u_s (
    .clk(clk), .rst(rst), .en(en), .up_down(up_down), .step(step), .load(load),
    .load_val(load_val), .count(s_count), .at_max(s_max), .at_min(s_min), .wrap(s_wrap), .err(s_err)
  );
  updown_counter_mod #(.WIDTH(8), .MAX_VAL(255), .SAT_MODE(0)) u_b (
    .clk(clk), .rst(rst), .en(b_en), .up_down(b_up), .step(8'd1), .load(1'b0),
    .load_val(8'd0), .count(b_count), .at_max(b_max), .at_min(b_min), .wrap(b_wrap), .err(b_err)
  );
  initial forever begin
    @(posedge clk);
    #1;
    while (q.size() > 0) begin
      exp_t e;
      logic [7:0] c;
      logic w, er, mx, mn;
      int mv;
      e = q.pop_front();
      case (e.id)
        0: begin c = {4'd0, w_count}; w = w_wrap; er = w_err; mx = w_max; mn = w_min; mv = 9; end
        1: begin c = {4'd0, s_count}; w = s_wrap; er = s_err; mx = s_max; mn = s_min; mv = 9; end
        default: begin c = b_count; w = b_wrap; er = b_err; mx = b_max; mn = b_min; mv = 255; end
      endcase
      checks++;
      if (c !== 8'(e.cnt) || w !== e.wr || er !== e.er || mx !== (e.cnt == mv) || mn !== (e.cnt == 0)) begin
        errors++;
        $display("FAIL %s: got count=%0d wrap=%b err=%b at_max=%b at_min=%b, expected count=%0d wrap=%b err=%b at_max=%b at_min=%b",
                 e.tag, c, w, er, mx, mn, e.cnt, e.wr, e.er, e.cnt == mv, e.cnt == 0);
      end
    end
  end
  task automatic cyc(input bit r, l, e, u, input int s, lv, id, cnt, input bit wr, er, input string tag);
    rst = r;
    load = l;
    en = e;
    up_down = u;
    step = 4'(s);
    load_val = 4'(lv);
    @(posedge clk);
    q.push_back('{id, cnt, wr, er, tag});
    @(negedge clk);
  endtask
  initial begin
    int m;
    bit mw;
    b_en = 1'b0;
    b_up = 1'b0;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst1");
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, "rst2_sat");
    for (int i = 1; i <= 12; i++) cyc(0, 0, 1, 1, 1, 0, 0, i % 10, i == 10, 0, $sformatf("up%0d", i));
    cyc(0, 1, 0, 0, 0, 2, 0, 2, 0, 0, "load2");
    cyc(0, 0, 1, 0, 3, 0, 0, 9, 1, 0, "down3_wrap");
    cyc(0, 0, 1, 0, 3, 0, 0, 6, 0, 0, "down3");
    cyc(0, 1, 0, 0, 0, 12, 0, 9, 0, 1, "load12_clip");
    cyc(0, 0, 0, 0, 0, 0, 0, 9, 0, 0, "idle_clears_err");
    cyc(0, 1, 0, 0, 0, 7, 1, 7, 0, 0, "sat_load7");
    cyc(0, 0, 1, 1, 4, 0, 1, 9, 1, 0, "sat_up4");
    cyc(0, 0, 1, 1, 4, 0, 1, 9, 1, 0, "sat_hold_max");
    cyc(0, 0, 1, 0, 9, 0, 1, 0, 0, 0, "sat_down9");
    cyc(0, 0, 1, 0, 1, 0, 1, 0, 1, 0, "sat_hold_min");
    cyc(0, 1, 0, 0, 0, 4, 0, 4, 0, 0, "load4");
    cyc(0, 0, 1, 1, 10, 0, 0, 4, 0, 1, "step10_err");
    cyc(0, 0, 1, 1, 0, 0, 0, 4, 0, 0, "step0_hold");
    cyc(0, 0, 0, 1, 3, 0, 0, 4, 0, 0, "en0_hold");
    cyc(0, 1, 1, 1, 3, 5, 0, 5, 0, 0, "load_over_en");
    cyc(1, 1, 1, 1, 3, 7, 0, 0, 0, 0, "rst_over_load");
    cyc(0, 0, 1, 1, 2, 0, 0, 2, 0, 0, "resume_after_rst");
    cyc(0, 1, 0, 0, 0, 9, 0, 9, 0, 0, "load9_at_max");
    cyc(1, 0, 0, 0, 0, 0, 2, 0, 0, 0, "bin_rst");
    rst = 1'b0;
    m = 0;
    for (int i = 0; i < 1000; i++) begin
      b_en = 1'($urandom_range(0, 3) != 0);
      b_up = 1'($urandom_range(0, 1));
      mw = 1'b0;
      if (b_en) begin
        if (b_up) begin
          mw = m == 255;
          m = (m + 1) % 256;
        end else begin
          mw = m == 0;
          m = (m + 255) % 256;
        end
      end
      @(posedge clk);
      q.push_back('{2, m, mw, 1'b0, $sformatf("bin%0d", i)});
      @(negedge clk);
    end
    b_en = 1'b0;
    @(posedge clk);
    #2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
